// File: rtl/apbuart_ctrl.sv
// apbuart_ctrl: APB master that configures an apbuart and then bridges its data register to rx/tx byte streams
module apbuart_ctrl #(
  parameter logic [31:0] PADDR = 32'h0000_0000,
  parameter int SBITS = 12,
  parameter logic [SBITS-1:0] SCALER = 12'd53,
  parameter logic [4:0] CTRL_OPT = 5'b00000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        cfg_done,
  output logic [7:0]  err_cnt
);
  typedef enum logic [2:0] {CFG_SCL, CFG_CTL, POLL, RD, WR} state_t;
  state_t st, nxt;
  logic done, err;
  logic [31:0] off, wdata;
  always_comb begin
    done = psel & penable & pready;
    err = |prdata[6:4];
    nxt = !done ? st :
          st == CFG_SCL ? CFG_CTL :
          st != POLL ? POLL :
          (prdata[0] && !rx_valid) ? RD :
          (prdata[2] && tx_valid) ? WR : POLL;
    off = nxt == CFG_SCL ? 32'hC : nxt == CFG_CTL ? 32'h8 : nxt == POLL ? 32'h4 : 32'h0;
    wdata = nxt == CFG_SCL ? 32'(SCALER) :
            nxt == CFG_CTL ? {25'b0, CTRL_OPT, 2'b11} :
            nxt == WR ? {24'b0, tx_data} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st <= CFG_SCL;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= 32'h0;
      pwdata <= 32'h0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= 8'h0;
      cfg_done <= 1'b0;
      err_cnt <= 8'h0;
    end else begin
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (!psel || done) begin
        st <= nxt;
        psel <= 1'b1;
        penable <= 1'b0;
        paddr <= PADDR + off;
        pwrite <= nxt inside {CFG_SCL, CFG_CTL, WR};
        pwdata <= wdata;
      end else penable <= 1'b1;
      if (done && st == CFG_CTL) cfg_done <= 1'b1;
      if (done && st == POLL && err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h1;
      if (done && st == POLL && nxt == WR) tx_ready <= 1'b1;
      if (done && st == RD) begin
        rx_data <= prdata[7:0];
        rx_valid <= 1'b1;
      end
    end
  end
endmodule
